// File: rtl/pwm_output_stage.sv
// pwm_output_stage: turns the SPI-written configuration registers into 16 output pins.
// Each pin is forced low, held statically high, or driven by one shared PWM waveform.
// A prescaler slows the 8-bit period counter. The duty value is shadowed and reloads only
// at a period boundary, so an SPI write in the middle of a period cannot cause a glitch.

module pwm_output_stage #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] uo_pwm_out,
    output logic        pwm_period_start
);

    // A prescaler that divides by 1 still needs a 1-bit counter so that the port widths stay legal.
    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic [7:0]         pwm_cnt;
    logic [7:0]         duty_sh;
    logic               wrap;
    logic               pwm_sig;
    logic [15:0]        en_out;
    logic [15:0]        en_pwm;
    logic [15:0]        out_next;

    // Configuration registers arrive as byte halves. The inputs are already quasi-static in the clk domain.
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Tick on the last prescaler state. When CLK_DIV is 1, the only state is 0, so tick is always high.
    always_comb begin
        tick = (presc_cnt == PRESC_MAX);
        wrap = tick & (pwm_cnt == 8'hFF);
    end

    // Prescaler: counts 0..CLK_DIV-1 and then wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Period counter: advances once per tick and wraps naturally modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Shadow duty register plus boundary pulse. A duty write in the same cycle as the wrap is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh          <= 8'h00;
            pwm_period_start <= 1'b0;
        end else begin
            pwm_period_start <= wrap;
            if (wrap) begin
                duty_sh <= pwm_duty_cycle;
            end
        end
    end

    // Shared PWM level. 0xFF is special-cased so that full duty has no low count at all.
    always_comb begin
        pwm_sig = (duty_sh == 8'hFF) ? 1'b1 : (pwm_cnt < duty_sh);
    end

    // Per-pin mode select: disabled -> low, static mode -> high, PWM mode -> shared waveform.
    always_comb begin
        out_next = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (en_out[i]) begin
                out_next[i] = en_pwm[i] ? pwm_sig : 1'b1;
            end
        end
    end

    // Output pins are registered every clk. Enable and mode changes are not deferred to the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_pwm_out <= 16'h0000;
        end else begin
            uo_pwm_out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage. It runs two instances side by side (CLK_DIV = 1 and 10) on shared inputs.
// The reference model works from the number of clock edges elapsed since reset.

module tb_pwm_output_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_o_lo = 8'h00;
    logic [7:0]  en_o_hi = 8'h00;
    logic [7:0]  en_p_lo = 8'h00;
    logic [7:0]  en_p_hi = 8'h00;
    logic [7:0]  duty = 8'h00;
    logic [15:0] uo1;
    logic [15:0] uo10;
    logic        ps1;
    logic        ps10;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    bit          check_en = 1'b0;

    pwm_output_stage #(.CLK_DIV(1)) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_reg_out_7_0   (en_o_lo),
        .en_reg_out_15_8  (en_o_hi),
        .en_reg_pwm_7_0   (en_p_lo),
        .en_reg_pwm_15_8  (en_p_hi),
        .pwm_duty_cycle   (duty),
        .uo_pwm_out       (uo1),
        .pwm_period_start (ps1)
    );

    pwm_output_stage #(.CLK_DIV(10)) dut10 (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_reg_out_7_0   (en_o_lo),
        .en_reg_out_15_8  (en_o_hi),
        .en_reg_pwm_7_0   (en_p_lo),
        .en_reg_pwm_15_8  (en_p_hi),
        .pwm_duty_cycle   (duty),
        .uo_pwm_out       (uo10),
        .pwm_period_start (ps10)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: pin levels derived from elapsed edges, period length and the duty captured at the last boundary.
    int unsigned n1, n10;
    logic [7:0]  sh1, sh10;
    logic [15:0] exp_uo1, exp_uo10;
    logic        exp_ps1, exp_ps10;

    function automatic logic [15:0] model_out(input int unsigned elapsed, input int unsigned div,
                                              input logic [7:0] sh, input logic [15:0] eo,
                                              input logic [15:0] ep);
        int unsigned cnt;
        logic        sig;
        cnt = (elapsed / div) % 256;
        sig = (sh == 8'hFF) ? 1'b1 : (cnt < 32'(sh));
        return (eo & ep & {16{sig}}) | (eo & ~ep);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1 <= 0; n10 <= 0; sh1 <= 8'h00; sh10 <= 8'h00;
            exp_uo1 <= 16'h0; exp_uo10 <= 16'h0; exp_ps1 <= 1'b0; exp_ps10 <= 1'b0;
        end else begin
            exp_uo1  <= model_out(n1, 1, sh1, {en_o_hi, en_o_lo}, {en_p_hi, en_p_lo});
            exp_uo10 <= model_out(n10, 10, sh10, {en_o_hi, en_o_lo}, {en_p_hi, en_p_lo});
            n1  <= n1 + 1;
            n10 <= n10 + 1;
            exp_ps1  <= ((n1 + 1) % 256) == 0;
            exp_ps10 <= ((n10 + 1) % 2560) == 0;
            if (((n1 + 1) % 256) == 0) sh1 <= duty;
            if (((n10 + 1) % 2560) == 0) sh10 <= duty;
        end
    end

    // Compare on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("dut1_out", 32'(uo1), 32'(exp_uo1));
            check("dut1_start", 32'(ps1), 32'(exp_ps1));
            check("dut10_out", 32'(uo10), 32'(exp_uo10));
            check("dut10_start", 32'(ps10), 32'(exp_ps10));
        end
    end

    task automatic wait_start(input bit on10, input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            seen = on10 ? ps10 : ps1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int highs;
        int pulses;
        int first1;
        int first10;

        // Power-on reset
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // T2: static high on all pins, then a subset, then the high byte only
        en_o_hi = 8'hFF; en_o_lo = 8'hFF;
        @(negedge clk);
        check("t2_static_ffff_d1", 32'(uo1), 32'h0000FFFF);
        check("t2_static_ffff_d10", 32'(uo10), 32'h0000FFFF);
        en_o_hi = 8'h00; en_o_lo = 8'hF0;
        @(negedge clk);
        check("t2_static_00f0_d1", 32'(uo1), 32'h000000F0);
        check("t2_static_00f0_d10", 32'(uo10), 32'h000000F0);
        en_o_hi = 8'hA5; en_o_lo = 8'h00;
        @(negedge clk);
        check("t2_static_a500", 32'(uo10), 32'h0000A500);

        // T1: async reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("t1_reset_out_d1", 32'(uo1), 32'h0);
        check("t1_reset_start_d1", 32'(ps1), 32'h0);
        check("t1_reset_out_d10", 32'(uo10), 32'h0);
        check("t1_reset_start_d10", 32'(ps10), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en_o_hi = 8'h00; en_o_lo = 8'h01; en_p_hi = 8'h00; en_p_lo = 8'h01;
        duty = 8'h80;

        // T3: 50% duty, CLK_DIV=1
        wait_start(1'b0, 300, "t3_first_start");
        check("t3_bit0_at_start", 32'(uo1[0]), 32'd0);
        highs = 0; pulses = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (k == 1) check("t3_rise_after_start", 32'(uo1[0]), 32'd1);
            if (uo1[0]) highs++;
            if (ps1) pulses++;
        end
        check("t3_high_count", 32'(highs), 32'd128);
        check("t3_pulse_count", 32'(pulses), 32'd1);
        check("t3_pulse_at_256", 32'(ps1), 32'd1);

        // T4: duty extremes over three periods each
        duty = 8'h00;
        wait_start(1'b0, 300, "t4_zero_start");
        highs = 0; pulses = 0;
        for (int k = 1; k <= 768; k++) begin
            @(negedge clk);
            if (uo1[0]) highs++;
            if (ps1) pulses++;
        end
        check("t4_zero_highs", 32'(highs), 32'd0);
        check("t4_zero_pulses", 32'(pulses), 32'd3);
        duty = 8'hFF;
        wait_start(1'b0, 300, "t4_full_start");
        highs = 0;
        for (int k = 1; k <= 768; k++) begin
            @(negedge clk);
            if (uo1[0]) highs++;
        end
        check("t4_full_highs", 32'(highs), 32'd768);

        // T5: shadowing with CLK_DIV=10; 0xC0 is written when pwm_cnt is 0x20
        duty = 8'h40;
        wait_start(1'b1, 3000, "t5_start");
        highs = 0;
        for (int k = 1; k <= 2560; k++) begin
            @(negedge clk);
            if (uo10[0]) highs++;
            if (k == 320) duty = 8'hC0;
        end
        check("t5_old_period_highs", 32'(highs), 32'd640);
        check("t5_boundary_pulse", 32'(ps10), 32'd1);
        highs = 0;
        for (int k = 1; k <= 2560; k++) begin
            @(negedge clk);
            if (uo10[0]) highs++;
        end
        check("t5_new_period_highs", 32'(highs), 32'd1920);

        // T6: reset at pwm_cnt=0x90 while bit0 is high
        repeat (1440) @(negedge clk);
        check("t6_bit0_high_before", 32'(uo10[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_out_d10", 32'(uo10), 32'h0);
        check("t6_reset_out_d1", 32'(uo1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0; first1 = 0; first10 = 0;
        for (int k = 1; k <= 2560; k++) begin
            @(negedge clk);
            if (uo10[0]) highs++;
            if (ps1 && first1 == 0) first1 = k;
            if (ps10 && first10 == 0) first10 = k;
        end
        check("t6_first_start_d10", 32'(first10), 32'd2560);
        check("t6_first_start_d1", 32'(first1), 32'd256);
        check("t6_bit0_low_until_start", 32'(highs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
